// File: rtl/div_pkg.sv
// div_pkg: shared FSM states, default width and error constants for the divider
package div_pkg;
    localparam int DIV_W = 16;
    localparam logic [DIV_W-1:0] ERR_QUOTIENT = '1;
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration
module div_step
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic [W-1:0] p,
    input  logic         q_msb,
    input  logic [W-1:0] d,
    output logic [W-1:0] p_next,
    output logic         qbit
);
    logic [W:0] t;
    logic [W:0] diff;
    // shift in the next dividend bit and subtract when the divisor fits; P<D keeps T below 2D
    always_comb begin
        t      = {p, q_msb};
        diff   = t - {1'b0, d};
        qbit   = t >= {1'b0, d};
        p_next = qbit ? diff[W-1:0] : t[W-1:0];
    end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, 2W/W -> W quotient and W remainder
module seq_divider
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           err
);
    localparam int CW = $clog2(W) + 1;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [W-1:0] p, q, d, p_next;
    logic qbit, op_err, last;
    div_step #(.W(W)) u_step (
        .p      (p),
        .q_msb  (q[W-1]),
        .d      (d),
        .p_next (p_next),
        .qbit   (qbit)
    );
    // next state, handshake outputs and the accept-time error check
    always_comb begin
        op_err    = divisor == '0 || dividend[2*W-1:W] >= divisor;
        last      = cnt == CW'(W - 1);
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        state_nx  = state;
        case (state)
            IDLE:    state_nx = in_valid ? (op_err ? DONE : CALC) : IDLE;
            CALC:    state_nx = last ? DONE : CALC;
            DONE:    state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    // operand capture, iteration and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p         <= '0;
            q         <= '0;
            d         <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            err       <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            p   <= dividend[2*W-1:W];
            q   <= dividend[W-1:0];
            d   <= divisor;
            cnt <= '0;
            if (op_err) begin
                quotient  <= {W{ERR_QUOTIENT[0]}};
                remainder <= dividend[W-1:0];
                err       <= 1'b1;
            end
        end else if (state == CALC) begin
            p   <= p_next;
            q   <= {q[W-2:0], qbit};
            cnt <= cnt + 1'b1;
            if (last) begin
                quotient  <= {q[W-2:0], qbit};
                remainder <= p_next;
                err       <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and scoreboarded checks of the sequential divider
module tb_seq_divider;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        err;
    int vectors = 0;
    int miscompares = 0;

    seq_divider #(.W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .err       (err)
    );

    always #5 clk = ~clk;

    // present one operation while idle; returns just after the accept edge
    task automatic start(input logic [31:0] a, input logic [15:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // count clock edges after the accept edge until out_valid shows (bounded)
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk);
            #1 cyc++;
        end
    endtask

    task automatic pop();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || err !== 1'b0 || quotient !== 16'h0 || remainder !== 16'h0) begin
            miscompares++;
            $display("FAIL reset: in_ready=%b out_valid=%b err=%b q=%h r=%h, want 1 0 0 0000 0000", in_ready, out_valid, err, quotient, remainder);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int cyc;
        start(32'd100, 16'd7);
        wait_done(cyc);
        vectors++;
        if (cyc !== 16) begin miscompares++; $display("FAIL basic latency: got %0d want 16", cyc); end
        vectors++;
        if (quotient !== 16'd14 || remainder !== 16'd2 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL basic 100/7: q=%0d r=%0d err=%b want 14 2 0", quotient, remainder, err);
        end
        pop();
    endtask

    task automatic test_max();
        int cyc;
        start(32'hFFFE_0001, 16'hFFFF);
        wait_done(cyc);
        vectors++;
        if (cyc !== 16 || quotient !== 16'hFFFF || remainder !== 16'h0000 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL max exact: lat=%0d q=%h r=%h err=%b want 16 ffff 0000 0", cyc, quotient, remainder, err);
        end
        pop();
        start(32'hFFFE_FFFF, 16'hFFFF);
        wait_done(cyc);
        vectors++;
        if (cyc !== 16 || quotient !== 16'hFFFF || remainder !== 16'hFFFE || err !== 1'b0) begin
            miscompares++;
            $display("FAIL max rem: lat=%0d q=%h r=%h err=%b want 16 ffff fffe 0", cyc, quotient, remainder, err);
        end
        pop();
    endtask

    task automatic test_errors();
        int cyc;
        start(32'h1234_5678, 16'h0000);
        wait_done(cyc);
        vectors++;
        if (cyc !== 0 || err !== 1'b1 || quotient !== 16'hFFFF || remainder !== 16'h5678) begin
            miscompares++;
            $display("FAIL div0: lat=%0d err=%b q=%h r=%h want 0 1 ffff 5678", cyc, err, quotient, remainder);
        end
        pop();
        start(32'h0001_0000, 16'h0001);
        wait_done(cyc);
        vectors++;
        if (cyc !== 0 || err !== 1'b1 || quotient !== 16'hFFFF || remainder !== 16'h0000) begin
            miscompares++;
            $display("FAIL overflow: lat=%0d err=%b q=%h r=%h want 0 1 ffff 0000", cyc, err, quotient, remainder);
        end
        pop();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL err release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        start(32'd1000, 16'd3);
        wait_done(cyc);
        vectors++;
        if (cyc !== 16 || quotient !== 16'd333 || remainder !== 16'd1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL bp result: lat=%0d q=%0d r=%0d err=%b want 16 333 1 0", cyc, quotient, remainder, err);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid = (k == 3);
            dividend = 32'd50;
            divisor  = 16'd5;
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 16'd333 || remainder !== 16'd1) begin
                miscompares++;
                $display("FAIL bp hold %0d: out_valid=%b in_ready=%b q=%0d r=%0d want 1 0 333 1", k, out_valid, in_ready, quotient, remainder);
            end
        end
        in_valid = 1'b0;
        pop();
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp no accept: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_dd[$];
        logic [15:0] exp_dv[$];
        int got = 0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    logic [15:0] dv, hi;
                    int g;
                    dv = 16'($urandom_range(1, 65535));
                    hi = 16'($urandom_range(0, int'(dv) - 1));
                    @(negedge clk);
                    dividend = {hi, 16'($urandom)};
                    divisor  = dv;
                    in_valid = 1'b1;
                    g = 0;
                    while (!in_ready && g < 200) begin
                        @(negedge clk);
                        g++;
                    end
                    if (g >= 200) begin
                        miscompares++;
                        $display("FAIL b2b accept timeout: op %0d", i);
                        break;
                    end
                    exp_dd.push_back(dividend);
                    exp_dv.push_back(dv);
                    @(posedge clk);
                    #1 in_valid = 1'b0;
                end
                in_valid = 1'b0;
            end
            begin
                int cyc = 0;
                while (got < 1000 && cyc < 60000) begin
                    @(negedge clk);
                    cyc++;
                    out_ready = 1'($urandom_range(0, 1));
                    if (out_valid && out_ready) begin
                        logic [31:0] dd;
                        logic [15:0] dv, eq, er;
                        vectors++;
                        if (exp_dd.size() == 0) begin
                            miscompares++;
                            $display("FAIL b2b stray result: q=%h r=%h want none", quotient, remainder);
                        end else begin
                            dd = exp_dd.pop_front();
                            dv = exp_dv.pop_front();
                            eq = 16'(dd / {16'h0, dv});
                            er = 16'(dd % {16'h0, dv});
                            if (quotient !== eq || remainder !== er || err !== 1'b0) begin
                                miscompares++;
                                $display("FAIL b2b %0d: %h/%h got q=%h r=%h err=%b want q=%h r=%h err=0", got, dd, dv, quotient, remainder, err, eq, er);
                            end
                        end
                        got++;
                    end
                end
                out_ready = 1'b0;
                vectors++;
                if (got < 1000) begin
                    miscompares++;
                    $display("FAIL b2b timeout: got %0d results want 1000", got);
                end
            end
        join
    endtask

    task automatic test_reset_mid();
        int cyc;
        int stray = 0;
        start(32'hABCD_1234, 16'h0000);
        wait_done(cyc);
        pop();
        start(32'd100, 16'd7);
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || err !== 1'b0 || quotient !== 16'h0 || remainder !== 16'h0) begin
            miscompares++;
            $display("FAIL mid reset: in_ready=%b out_valid=%b err=%b q=%h r=%h want 1 0 0 0000 0000", in_ready, out_valid, err, quotient, remainder);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        vectors++;
        if (stray !== 0) begin miscompares++; $display("FAIL stray out_valid: %0d cycles want 0", stray); end
        start(32'd100, 16'd7);
        wait_done(cyc);
        vectors++;
        if (cyc !== 16 || quotient !== 16'd14 || remainder !== 16'd2 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL post reset 100/7: lat=%0d q=%0d r=%0d err=%b want 16 14 2 0", cyc, quotient, remainder, err);
        end
        pop();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
